// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM generator.
//   CNT_W      - width of the slot counter and of duty values
//   PERIOD_DEF - default number of ticks per PWM period
//   duty_t     - duty / slot index type
//   clamp_duty - saturating clamp of a requested duty to the period length
package pwm_pkg;

    localparam int CNT_W      = 8;
    localparam int PERIOD_DEF = 200;

    typedef logic [CNT_W-1:0] duty_t;

    // A duty longer than the period means "always high"; clamp it to the period.
    function automatic duty_t clamp_duty(input duty_t d, input duty_t lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// pwm_gen_if: duty-update valid/ready channel.
//   duty_in    - requested high time in ticks (master -> slave)
//   duty_valid - duty_in is valid               (master -> slave)
//   duty_ready - slave can accept a duty value  (slave -> master)
interface pwm_gen_if;
    import pwm_pkg::*;

    duty_t duty_in;
    logic  duty_valid;
    logic  duty_ready;

    modport master (output duty_in, output duty_valid, input  duty_ready);
    modport slave  (input  duty_in, input  duty_valid, output duty_ready);

endinterface

// File: rtl/pwm_gen_sync_edge.sv
// sync_edge: brings an asynchronous slow clock into clk_in with a 2-flop
// synchroniser and emits a one-cycle pulse on each synchronised rising edge.
//   clk_in     - destination clock
//   rst        - asynchronous active-low reset
//   async_in   - signal asynchronous to clk_in
//   rise_pulse - one clk_in cycle wide, high on a rising edge of async_in
module sync_edge (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;   // previous synchronised value, for edge detection
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: single-channel PWM with double-buffered duty updates.
//   clk_in       - system clock
//   rst          - asynchronous active-low reset
//   pwm_clk      - divided clock, each rising edge is one slot tick
//   enable       - run enable; when low the counter parks at PERIOD-1
//   duty_if      - duty update channel (slave side)
//   pwm_out      - registered PWM output, high for slots 0..duty-1
//   period_start - one-cycle pulse in the cycle after a wrapping tick
//   cnt_out      - current slot index
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       pwm_clk,
    input  logic       enable,
    pwm_gen_if.slave   duty_if,
    output logic       pwm_out,
    output logic       period_start,
    output duty_t      cnt_out
);

    localparam duty_t LAST = duty_t'(PERIOD - 1);
    localparam duty_t PER  = duty_t'(PERIOD);

    logic  tick;
    logic  wrap;
    duty_t duty_eff;

    duty_t cnt_q, cnt_d;
    duty_t active_q, active_d;
    duty_t pend_duty_q, pend_duty_d;
    logic  pending_q, pending_d;
    logic  pwm_q, pwm_d;
    logic  ps_q, ps_d;

    sync_edge u_sync (
        .clk_in    (clk_in),
        .rst       (rst),
        .async_in  (pwm_clk),
        .rise_pulse(tick)
    );

    always_comb begin
        cnt_d       = cnt_q;
        active_d    = active_q;
        pend_duty_d = pend_duty_q;
        pending_d   = pending_q;
        pwm_d       = pwm_q;
        ps_d        = 1'b0;
        wrap        = (cnt_q == LAST);
        duty_eff    = active_q;

        // Capture only needs pending=0 and a wrap only clears pending=1,
        // so the two updates of pending_d below never collide.
        if (duty_if.duty_valid && !pending_q) begin
            pend_duty_d = clamp_duty(duty_if.duty_in, PER);
            pending_d   = 1'b1;
        end

        if (!enable) begin
            // Park so the first tick after re-enable starts a fresh period.
            cnt_d = LAST;
            pwm_d = 1'b0;
        end else if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap && pending_q) begin
                active_d  = pend_duty_q;
                pending_d = 1'b0;
                duty_eff  = pend_duty_q;  // new duty already governs slot 0
            end
            pwm_d = (cnt_d < duty_eff);
            ps_d  = wrap;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_q       <= LAST;
            active_q    <= '0;
            pend_duty_q <= '0;
            pending_q   <= 1'b0;
            pwm_q       <= 1'b0;
            ps_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            pend_duty_q <= pend_duty_d;
            pending_q   <= pending_d;
            pwm_q       <= pwm_d;
            ps_q        <= ps_d;
        end
    end

    assign duty_if.duty_ready = ~pending_q;
    assign pwm_out            = pwm_q;
    assign period_start       = ps_q;
    assign cnt_out            = cnt_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: scoreboard bench for pwm_gen with PERIOD=10. Stimulus pushes the
// expected (slot, pwm, period_start) for every output update into a queue; a
// monitor pops and compares whenever cnt_out or pwm_out changes.
module tb_pwm_gen;
    import pwm_pkg::*;

    localparam int P = 10;

    typedef struct {
        int cnt;
        int pwm;
        int ps;
    } exp_t;

    logic  clk_in = 1'b0;
    logic  rst    = 1'b0;
    logic  pwm_clk = 1'b0;
    logic  enable = 1'b0;
    logic  pwm_out, period_start;
    duty_t cnt_out;

    pwm_gen_if duty_if ();

    pwm_gen #(.PERIOD(P)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .pwm_clk     (pwm_clk),
        .enable      (enable),
        .duty_if     (duty_if),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .cnt_out     (cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model: slot position, duty in force, buffered duty.
    int m_slot = P - 1;
    int m_act  = 0;
    int m_pend = 0;
    int m_pdut = 0;
    int m_pwm  = 0;
    int hold_v = 0;
    int hold_d = 0;
    int captured = 0;

    task automatic chk_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clampd(input int d);
        return (d > P) ? P : d;
    endfunction

    task automatic model_reset();
        m_slot = P - 1; m_act = 0; m_pend = 0; m_pdut = 0; m_pwm = 0;
        hold_v = 0; captured = 0;
        exp_q.delete();
    endtask

    // One slot tick as seen by the specification.
    task automatic model_tick();
        exp_t e;
        if (!enable) return;
        m_slot = (m_slot + 1) % P;
        if (m_slot == 0 && m_pend != 0) begin
            m_act  = m_pdut;
            m_pend = 0;
        end
        m_pwm = (m_slot < m_act) ? 1 : 0;
        e.cnt = m_slot; e.pwm = m_pwm; e.ps = (m_slot == 0) ? 1 : 0;
        exp_q.push_back(e);
        // A valid held across the wrap is accepted once the buffer frees up.
        if (hold_v != 0 && m_pend == 0) begin
            m_pend = 1;
            m_pdut = clampd(hold_d);
            captured = 1;
        end
    endtask

    // Monitor: compare on every visible output update.
    initial begin
        int   prev_cnt;
        int   prev_pwm;
        exp_t e;
        prev_cnt = P - 1;
        prev_pwm = 0;
        forever begin
            @(negedge clk_in);
            if (rst) begin
                if (int'(cnt_out) != prev_cnt || int'(pwm_out) != prev_pwm) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mon_unexpected: got cnt=%0d pwm=%0d with nothing expected at %0t",
                                 cnt_out, pwm_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk_eq("mon_cnt", int'(cnt_out), e.cnt);
                        chk_eq("mon_pwm", int'(pwm_out), e.pwm);
                        chk_eq("mon_ps", int'(period_start), e.ps);
                    end
                end else begin
                    chk_eq("idle_ps", int'(period_start), 0);
                end
            end
            prev_cnt = int'(cnt_out);
            prev_pwm = int'(pwm_out);
        end
    end

    // One pwm_clk pulse; all tasks start and end at posedge+1.
    task automatic do_tick();
        int h, l;
        h = $urandom_range(3, 6);
        l = $urandom_range(3, 6);
        captured = 0;
        pwm_clk = 1'b1;
        model_tick();
        repeat (h) @(posedge clk_in);
        #1 pwm_clk = 1'b0;
        repeat (l) @(posedge clk_in);
        #1;
        if (captured != 0) begin
            duty_if.duty_valid = 1'b0;
            hold_v = 0;
        end
        chk_eq("drain", exp_q.size(), 0);
        chk_eq("ready", int'(duty_if.duty_ready), (m_pend == 0) ? 1 : 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic send(input int d);
        chk_eq("ready_pre", int'(duty_if.duty_ready), 1);
        duty_if.duty_in    = duty_t'(d);
        duty_if.duty_valid = 1'b1;
        @(posedge clk_in);
        #1 duty_if.duty_valid = 1'b0;
        m_pend = 1;
        m_pdut = clampd(d);
        chk_eq("ready_drop", int'(duty_if.duty_ready), 0);
    endtask

    task automatic set_enable(input logic en);
        exp_t e;
        enable = en;
        if (!en && (m_slot != P - 1 || m_pwm != 0)) begin
            e.cnt = P - 1; e.pwm = 0; e.ps = 0;
            exp_q.push_back(e);
        end
        if (!en) begin
            m_slot = P - 1;
            m_pwm  = 0;
        end
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1 chk_eq("en_drain", exp_q.size(), 0);
    endtask

    initial begin
        int old_slot;
        int guard;
        duty_if.duty_in    = '0;
        duty_if.duty_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        chk_eq("rst_cnt", int'(cnt_out), P - 1);
        chk_eq("rst_pwm", int'(pwm_out), 0);
        chk_eq("rst_ps", int'(period_start), 0);
        chk_eq("rst_ready", int'(duty_if.duty_ready), 1);
        rst = 1'b1;
        @(posedge clk_in);
        #1 enable = 1'b1;

        // Basic duty 3, two periods.
        send(3);
        ticks(20);

        // Boundaries: 0, full period, clamped.
        send(0);  ticks(10);
        send(10); ticks(10);
        send(15); ticks(10);

        // Update mid-period with a second request held off by ready.
        send(3);  ticks(5);
        send(7);
        hold_v = 1; hold_d = 2;
        duty_if.duty_in    = duty_t'(2);
        duty_if.duty_valid = 1'b1;
        ticks(6);
        ticks(10);
        ticks(10);

        // Tick latency for one isolated edge.
        old_slot = m_slot;
        pwm_clk = 1'b1;
        model_tick();
        @(posedge clk_in);
        @(negedge clk_in) chk_eq("lat_e0", int'(cnt_out), old_slot);
        @(posedge clk_in);
        @(negedge clk_in) chk_eq("lat_e1", int'(cnt_out), old_slot);
        @(posedge clk_in);
        @(negedge clk_in) chk_eq("lat_e2", int'(cnt_out), m_slot);
        repeat (3) @(posedge clk_in);
        #1 pwm_clk = 1'b0;
        repeat (6) @(posedge clk_in);
        #1 chk_eq("lat_single", int'(cnt_out), m_slot);

        // Enable drop at slot 5.
        guard = 0;
        while (m_slot != 5 && guard < 20) begin do_tick(); guard++; end
        chk_eq("slot5_reached", m_slot, 5);
        set_enable(1'b0);
        chk_eq("dis_cnt", int'(cnt_out), P - 1);
        chk_eq("dis_pwm", int'(pwm_out), 0);
        ticks(2);
        set_enable(1'b1);
        do_tick();
        chk_eq("reen_slot", int'(cnt_out), 0);

        // Randomized mix of ticks, updates and enable toggles.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                if (m_pend == 0) send($urandom_range(0, 20));
            end else if (r == 2) begin
                set_enable(~enable);
            end else begin
                do_tick();
            end
        end
        if (!enable) set_enable(1'b1);

        // Asynchronous reset with a pending duty in flight.
        guard = 0;
        while ((m_pend != 0 || m_slot != 2) && guard < 30) begin do_tick(); guard++; end
        send(4);
        do_tick();
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk_eq("arst_pwm", int'(pwm_out), 0);
        chk_eq("arst_ready", int'(duty_if.duty_ready), 1);
        chk_eq("arst_cnt", int'(cnt_out), P - 1);
        chk_eq("arst_ps", int'(period_start), 0);
        repeat (2) @(posedge clk_in);
        #3 rst = 1'b1;
        @(posedge clk_in);
        #1 ticks(12);

        repeat (4) @(posedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
